allocate_gr_writeback_arbiter: RTL and testbench

Shares the single write port of the general register file between three writeback sources: ALU, load/store, and multiply/divide. Each source gets a one-entry holding buffer. A round-robin arbiter drains one buffer per cycle into a registered write port, which drives the register file's write valid, address and data inputs directly. An optional pending-register mask lets dispatch stall reads of registers whose writeback is still in flight.

---
 rtl/allocate_gr_writeback_arbiter.sv | 164 ++++++++++++++++
 tb/tb_allocate_gr_writeback_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/allocate_gr_writeback_arbiter.sv
// allocate_gr_writeback_arbiter: shares the general register file write port
// between the ALU (0), LSU (1) and MULDIV (2) writeback sources. Each source
// has a one-entry holding buffer; a round-robin arbiter drains one buffer per
// cycle into a registered write port.
// Optional feature macro: ALLOCATE_GR_WB_PENDING_EN builds the pending-register
// mask; without it oREG_PENDING is tied to zero.
module allocate_gr_writeback_arbiter (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iRESET_SYNC,
  input  logic        iREQ0_VALID,
  input  logic [4:0]  iREQ0_ADDR,
  input  logic [31:0] iREQ0_DATA,
  output logic        oREQ0_BUSY,
  input  logic        iREQ1_VALID,
  input  logic [4:0]  iREQ1_ADDR,
  input  logic [31:0] iREQ1_DATA,
  output logic        oREQ1_BUSY,
  input  logic        iREQ2_VALID,
  input  logic [4:0]  iREQ2_ADDR,
  input  logic [31:0] iREQ2_DATA,
  output logic        oREQ2_BUSY,
  output logic        oWR_VALID,
  output logic [4:0]  oWR_ADDR,
  output logic [31:0] oWR_DATA,
  output logic [31:0] oREG_PENDING
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned NS = 3;

  logic          clear_c;
  logic [NS-1:0] req_valid;
  logic [AW-1:0] req_addr [NS];
  logic [DW-1:0] req_data [NS];

  logic [NS-1:0] full_q, full_d;
  logic [AW-1:0] addr_q [NS];
  logic [AW-1:0] addr_d [NS];
  logic [DW-1:0] data_q [NS];
  logic [DW-1:0] data_d [NS];
  logic [1:0]    last_q, last_d;
  logic          wr_valid_q, wr_valid_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;

  logic [1:0]    ord0, ord1, ord2;
  logic [1:0]    gidx;
  logic          any_full;
  logic [NS-1:0] grant;
  logic [NS-1:0] busy_c;
  logic [NS-1:0] accept;

  assign clear_c = !inRESET || iRESET_SYNC;

  // Gather the per-source request ports into indexable form.
  always_comb begin
    req_valid   = {iREQ2_VALID, iREQ1_VALID, iREQ0_VALID};
    req_addr[0] = iREQ0_ADDR;
    req_addr[1] = iREQ1_ADDR;
    req_addr[2] = iREQ2_ADDR;
    req_data[0] = iREQ0_DATA;
    req_data[1] = iREQ1_DATA;
    req_data[2] = iREQ2_DATA;
  end

  // Round-robin search starting after the most recent grant.
  always_comb begin
    ord0 = 2'd0;
    ord1 = 2'd1;
    ord2 = 2'd2;
    case (last_q)
      2'd0: begin ord0 = 2'd1; ord1 = 2'd2; ord2 = 2'd0; end
      2'd1: begin ord0 = 2'd2; ord1 = 2'd0; ord2 = 2'd1; end
      default: begin ord0 = 2'd0; ord1 = 2'd1; ord2 = 2'd2; end
    endcase
    any_full = |full_q;
    gidx     = last_q;
    if (full_q[ord0])      gidx = ord0;
    else if (full_q[ord1]) gidx = ord1;
    else if (full_q[ord2]) gidx = ord2;
    grant = any_full ? NS'(3'b001 << gidx) : '0;
  end

  // Busy depends only on buffer state and the clear inputs.
  always_comb begin
    busy_c = clear_c ? '1 : (full_q & ~grant);
    accept = req_valid & ~busy_c;
  end

  assign oREQ0_BUSY = busy_c[0];
  assign oREQ1_BUSY = busy_c[1];
  assign oREQ2_BUSY = busy_c[2];

  // Next-state: buffer load/drain, grant pointer and write port.
  always_comb begin
    full_d     = full_q;
    last_d     = last_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    for (int i = 0; i < NS; i++) begin
      addr_d[i] = addr_q[i];
      data_d[i] = data_q[i];
      if (accept[i]) begin
        full_d[i] = 1'b1;
        addr_d[i] = req_addr[i];
        data_d[i] = req_data[i];
      end else if (grant[i]) begin
        full_d[i] = 1'b0;
      end
    end
    if (any_full) begin
      last_d     = gidx;
      wr_valid_d = 1'b1;
      wr_addr_d  = addr_q[gidx];
      wr_data_d  = data_q[gidx];
    end
  end

  // State registers with synchronous clear.
  always_ff @(posedge iCLOCK) begin
    if (clear_c) begin
      full_q     <= '0;
      last_q     <= 2'd2;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      for (int i = 0; i < NS; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      full_q     <= full_d;
      last_q     <= last_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      for (int i = 0; i < NS; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  assign oWR_VALID = wr_valid_q;
  assign oWR_ADDR  = wr_addr_q;
  assign oWR_DATA  = wr_data_q;

`ifdef ALLOCATE_GR_WB_PENDING_EN
  // Pending mask: every buffered destination plus the one on the write port.
  always_comb begin
    oREG_PENDING = '0;
    for (int i = 0; i < NS; i++) begin
      if (full_q[i]) oREG_PENDING = oREG_PENDING | (DW'(1) << addr_q[i]);
    end
    if (wr_valid_q) oREG_PENDING = oREG_PENDING | (DW'(1) << wr_addr_q);
  end
`else
  assign oREG_PENDING = 32'h0;
`endif

endmodule

// File: tb/tb_allocate_gr_writeback_arbiter.sv
// Directed bench for allocate_gr_writeback_arbiter: per-cycle vector table
// plus hand-written streaming and backpressure sequences.
module tb_allocate_gr_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst_n, sync;
  logic        v0, v1, v2;
  logic [4:0]  a0, a1, a2;
  logic [31:0] d0, d1, d2;
  logic        b0, b1, b2;
  logic        wv;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [31:0] pend;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  allocate_gr_writeback_arbiter dut (
    .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(sync),
    .iREQ0_VALID(v0), .iREQ0_ADDR(a0), .iREQ0_DATA(d0), .oREQ0_BUSY(b0),
    .iREQ1_VALID(v1), .iREQ1_ADDR(a1), .iREQ1_DATA(d1), .oREQ1_BUSY(b1),
    .iREQ2_VALID(v2), .iREQ2_ADDR(a2), .iREQ2_DATA(d2), .oREQ2_BUSY(b2),
    .oWR_VALID(wv), .oWR_ADDR(wa), .oWR_DATA(wd), .oREG_PENDING(pend)
  );

  typedef struct {
    logic        rst_n;
    logic        sync;
    logic [2:0]  v;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic [2:0]  busy;
    logic        wv;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] pend;
  } vec_t;

  localparam int NV = 29;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic r, input logic s, input logic [2:0] v,
                              input logic [4:0] xa0, input logic [31:0] xd0,
                              input logic [4:0] xa1, input logic [31:0] xd1,
                              input logic [4:0] xa2, input logic [31:0] xd2,
                              input logic [2:0] eb, input logic ev,
                              input logic [4:0] ea, input logic [31:0] ed,
                              input logic [31:0] ep);
    vec_t t;
    t.rst_n = r; t.sync = s; t.v = v;
    t.a0 = xa0; t.a1 = xa1; t.a2 = xa2;
    t.d0 = xd0; t.d1 = xd1; t.d2 = xd2;
    t.busy = eb; t.wv = ev; t.wa = ea; t.wd = ed; t.pend = ep;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_pend(input string name, input logic [31:0] exp);
`ifdef ALLOCATE_GR_WB_PENDING_EN
    chk(name, pend, exp);
`else
    chk(name, pend, 32'h0);
`endif
  endtask

  task automatic idle();
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    a0 = '0; a1 = '0; a2 = '0;
    d0 = '0; d1 = '0; d2 = '0;
  endtask

  initial begin
    rst_n = 1'b0; sync = 1'b0;
    idle();

    // Rows: rst_n, sync, valid{2,1,0}, a0,d0, a1,d1, a2,d2 | busy{2,1,0}, wv, wa, wd, pend
    tbl[0]  = mk(0,0,3'b000, 0,0, 0,0, 0,0,                 3'b111,0,0,0,0);
    // single request
    tbl[1]  = mk(1,0,3'b001, 3,32'hDEAD_BEEF, 0,0, 0,0,     3'b000,0,0,0,0);
    tbl[2]  = mk(1,0,3'b000, 0,0, 0,0, 0,0,                 3'b000,0,0,0,32'h8);
    tbl[3]  = mk(1,0,3'b000, 0,0, 0,0, 0,0,                 3'b000,1,3,32'hDEAD_BEEF,32'h8);
    tbl[4]  = mk(1,0,3'b000, 0,0, 0,0, 0,0,                 3'b000,0,3,32'hDEAD_BEEF,0);
    // clear, then three-way contention
    tbl[5]  = mk(1,1,3'b000, 0,0, 0,0, 0,0,                 3'b111,0,3,32'hDEAD_BEEF,0);
    tbl[6]  = mk(1,0,3'b111, 1,32'h11, 2,32'h22, 4,32'h44,  3'b000,0,0,0,0);
    tbl[7]  = mk(1,0,3'b000, 0,0, 0,0, 0,0,                 3'b110,0,0,0,32'h16);
    tbl[8]  = mk(1,0,3'b000, 0,0, 0,0, 0,0,                 3'b100,1,1,32'h11,32'h16);
    tbl[9]  = mk(1,0,3'b000, 0,0, 0,0, 0,0,                 3'b000,1,2,32'h22,32'h14);
    tbl[10] = mk(1,0,3'b000, 0,0, 0,0, 0,0,                 3'b000,1,4,32'h44,32'h10);
    // repeat round after a source-2 grant starts with source 0
    tbl[11] = mk(1,0,3'b111, 5,32'h55, 6,32'h66, 7,32'h77,  3'b000,0,4,32'h44,0);
    tbl[12] = mk(1,0,3'b000, 0,0, 0,0, 0,0,                 3'b110,0,4,32'h44,32'hE0);
    tbl[13] = mk(1,0,3'b000, 0,0, 0,0, 0,0,                 3'b100,1,5,32'h55,32'hE0);
    tbl[14] = mk(1,0,3'b000, 0,0, 0,0, 0,0,                 3'b000,1,6,32'h66,32'hC0);
    tbl[15] = mk(1,0,3'b000, 0,0, 0,0, 0,0,                 3'b000,1,7,32'h77,32'h80);
    tbl[16] = mk(1,0,3'b000, 0,0, 0,0, 0,0,                 3'b000,0,7,32'h77,0);
    // mid-flight clear with all buffers full and a write on the port
    tbl[17] = mk(1,0,3'b111, 1,32'hA1, 2,32'hA2, 3,32'hA3,  3'b000,0,7,32'h77,0);
    tbl[18] = mk(1,0,3'b001, 9,32'hA9, 0,0, 0,0,            3'b110,0,7,32'h77,32'hE);
    tbl[19] = mk(1,1,3'b010, 0,0, 10,32'hAA, 0,0,           3'b111,1,1,32'hA1,32'h20E);
    tbl[20] = mk(1,0,3'b111, 4,32'hB0, 5,32'hB1, 6,32'hB2,  3'b000,0,0,0,0);
    tbl[21] = mk(1,0,3'b000, 0,0, 0,0, 0,0,                 3'b110,0,0,0,32'h70);
    tbl[22] = mk(1,0,3'b000, 0,0, 0,0, 0,0,                 3'b100,1,4,32'hB0,32'h70);
    tbl[23] = mk(1,0,3'b000, 0,0, 0,0, 0,0,                 3'b000,1,5,32'hB1,32'h60);
    tbl[24] = mk(1,0,3'b000, 0,0, 0,0, 0,0,                 3'b000,1,6,32'hB2,32'h40);
    tbl[25] = mk(1,0,3'b000, 0,0, 0,0, 0,0,                 3'b000,0,6,32'hB2,0);
    // reset dominance over a valid request
    tbl[26] = mk(0,0,3'b001, 8,32'hC0, 0,0, 0,0,            3'b111,0,6,32'hB2,0);
    tbl[27] = mk(1,0,3'b000, 0,0, 0,0, 0,0,                 3'b000,0,0,0,0);
    tbl[28] = mk(1,0,3'b000, 0,0, 0,0, 0,0,                 3'b000,0,0,0,0);

    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      rst_n = tbl[i].rst_n; sync = tbl[i].sync;
      v0 = tbl[i].v[0]; v1 = tbl[i].v[1]; v2 = tbl[i].v[2];
      a0 = tbl[i].a0; a1 = tbl[i].a1; a2 = tbl[i].a2;
      d0 = tbl[i].d0; d1 = tbl[i].d1; d2 = tbl[i].d2;
      #1;
      chk($sformatf("row%0d_busy", i), 32'({b2, b1, b0}), 32'(tbl[i].busy));
      chk($sformatf("row%0d_wv", i), 32'(wv), 32'(tbl[i].wv));
      chk($sformatf("row%0d_wa", i), 32'(wa), 32'(tbl[i].wa));
      chk($sformatf("row%0d_wd", i), wd, tbl[i].wd);
      chk_pend($sformatf("row%0d_pend", i), tbl[i].pend);
      @(negedge clk);
    end

    // back-to-back stream from source 1, addrs 0..7
    idle();
    for (int k = 0; k <= 10; k++) begin
      logic [31:0] ep;
      v1 = (k < 8);
      a1 = 5'(k);
      d1 = 32'h100 + 32'(k);
      #1;
      chk($sformatf("b2b%0d_busy", k), 32'({b2, b1, b0}), 32'h0);
      chk($sformatf("b2b%0d_wv", k), 32'(wv), 32'((k >= 2 && k <= 9) ? 1 : 0));
      if (k >= 2 && k <= 9) begin
        chk($sformatf("b2b%0d_wa", k), 32'(wa), 32'(k - 2));
        chk($sformatf("b2b%0d_wd", k), wd, 32'h100 + 32'(k - 2));
      end
      ep = '0;
      if (k >= 1 && k <= 8) ep = ep | (32'h1 << (k - 1));
      if (k >= 2 && k <= 9) ep = ep | (32'h1 << (k - 2));
      chk_pend($sformatf("b2b%0d_pend", k), ep);
      @(negedge clk);
    end

    // clear before backpressure so source 0 has first priority
    idle();
    sync = 1'b1;
    #1;
    chk("bp_clear_busy", 32'({b2, b1, b0}), 32'h7);
    @(negedge clk);
    sync = 1'b0;

    // backpressure: sources 0 and 2 request continuously, 6 writes each
    begin
      int n0 = 0, n2 = 0, w0 = 0, w2 = 0, nw = 0;
      int cyc = 0;
      while ((w0 < 6 || w2 < 6) && cyc < 40) begin
        v0 = (n0 < 6); a0 = 5'(8 + n0);  d0 = 32'hA00 + 32'(n0);
        v2 = (n2 < 6); a2 = 5'(16 + n2); d2 = 32'hC00 + 32'(n2);
        #1;
        if (cyc >= 1 && n0 < 6 && n2 < 6) begin
          chk($sformatf("bp%0d_busy0", cyc), 32'(b0), 32'((cyc % 2 == 0) ? 1 : 0));
          chk($sformatf("bp%0d_busy2", cyc), 32'(b2), 32'((cyc % 2 == 1) ? 1 : 0));
        end
        if (wv) begin
          if (nw % 2 == 0) begin
            chk($sformatf("bp_w%0d_addr", nw), 32'(wa), 32'(8 + w0));
            chk($sformatf("bp_w%0d_data", nw), wd, 32'hA00 + 32'(w0));
            w0++;
          end else begin
            chk($sformatf("bp_w%0d_addr", nw), 32'(wa), 32'(16 + w2));
            chk($sformatf("bp_w%0d_data", nw), wd, 32'hC00 + 32'(w2));
            w2++;
          end
          nw++;
        end
        if (v0 && !b0) n0++;
        if (v2 && !b2) n2++;
        @(negedge clk);
        cyc++;
      end
      chk("bp_src0_writes", 32'(w0), 32'd6);
      chk("bp_src2_writes", 32'(w2), 32'd6);
      chk("bp_total_writes", 32'(nw), 32'd12);
    end

    idle();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
